// File: rtl/pcie_scr_pkg.sv
// Shared symbol constants, block types and per-symbol rules
// for the multilane scrambler control.
package pcie_scr_pkg;

  localparam logic [7:0] COM      = 8'hBC;
  localparam logic [7:0] SKP_K    = 8'h1C;
  localparam logic [7:0] TS1_ID   = 8'h1E;
  localparam logic [7:0] TS2_ID   = 8'h2D;
  localparam logic [7:0] EIEOS_ID = 8'h00;
  localparam logic [7:0] SKP_G3   = 8'hAA;

  localparam logic [1:0] SH_OS   = 2'b10;
  localparam logic [1:0] SH_DATA = 2'b01;

  typedef enum logic [2:0] {
    BT_IDLE,
    BT_DATA,
    BT_OS_TS,
    BT_OS_EIEOS,
    BT_OS_SKP,
    BT_OS_OTHER
  } blk_t;

  function automatic blk_t os_type(
    input logic [7:0] b0
  );
    blk_t t;
    case (b0)
      TS1_ID, TS2_ID: t = BT_OS_TS;
      EIEOS_ID:       t = BT_OS_EIEOS;
      SKP_G3:         t = BT_OS_SKP;
      default:        t = BT_OS_OTHER;
    endcase
    return t;
  endfunction

  function automatic logic sym_pos_advance(
    input blk_t t
  );
    return (t != BT_IDLE) && (t != BT_OS_SKP);
  endfunction

  // TS blocks keep the identifier and the last two symbols clear
  function automatic logic sym_pos_scrambled(
    input blk_t       t,
    input logic [3:0] s
  );
    return (t == BT_DATA) ||
           ((t == BT_OS_TS) && (s >= 4'd1) && (s <= 4'd13));
  endfunction

endpackage

// File: rtl/scr_ctrl_multilane_lane.sv
// One lane: symbol counter, block type, EIEOS pending
// and registered LFSR control outputs.
module scr_lane_ctrl
  import pcie_scr_pkg::*;
#(
  parameter int PB = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          gen3_i,
  input  logic          turn_off_i,
  input  logic          valid_i,
  input  logic          block_start_i,
  input  logic [1:0]    sync_header_i,
  input  logic [8*PB-1:0] data_i,
  input  logic [PB-1:0] datak_i,
  output logic          lfsr_reset_o,
  output logic [PB-1:0] advance_o,
  output logic [PB-1:0] scramble_en_o,
  output logic          block_err_o
);

  logic [3:0]    cnt_q, cnt_d;
  blk_t          type_q, type_d;
  logic          eieos_q, eieos_d;
  logic          lr_q, lr_d;
  logic          err_q, err_d;
  logic [PB-1:0] adv_q, adv_d;
  logic [PB-1:0] scr_q, scr_d;

  blk_t          dec, eff;
  logic          bad_sync, err_g3, pulse;
  logic [3:0]    base;
  logic [PB-1:0] adv_g3, scr_g3;
  logic [PB-1:0] adv_g1, scr_g1;
  logic          lr_g1;

  always_comb begin
    dec      = BT_IDLE;
    bad_sync = 1'b0;
    case (sync_header_i)
      SH_DATA: dec = BT_DATA;
      SH_OS:   dec = os_type(data_i[7:0]);
      default: bad_sync = 1'b1;
    endcase

    eff    = type_q;
    base   = cnt_q;
    err_g3 = 1'b0;
    pulse  = 1'b0;
    if (block_start_i) begin
      eff    = dec;
      base   = '0;
      err_g3 = bad_sync | (cnt_q != '0);
      pulse  = eieos_q & (dec != BT_IDLE);
    end else if (cnt_q == '0) begin
      // a live block that wrapped without a new start
      eff    = BT_IDLE;
      err_g3 = (type_q != BT_IDLE);
    end

    adv_g3 = '0;
    scr_g3 = '0;
    adv_g1 = '0;
    scr_g1 = '0;
    lr_g1  = 1'b0;
    for (int j = 0; j < PB; j++) begin
      adv_g3[j] = sym_pos_advance(eff);
      scr_g3[j] = sym_pos_scrambled(eff, base + 4'(j));
      adv_g1[j] = !(datak_i[j] &&
                    data_i[8*j +: 8] == SKP_K);
      scr_g1[j] = !datak_i[j];
      lr_g1     = lr_g1 | (datak_i[j] &&
                  data_i[8*j +: 8] == COM);
    end

    cnt_d   = cnt_q;
    type_d  = type_q;
    eieos_d = eieos_q;
    if (!gen3_i) begin
      cnt_d   = '0;
      type_d  = BT_IDLE;
      eieos_d = 1'b0;
    end else if (valid_i) begin
      cnt_d   = (eff == BT_IDLE) ? 4'd0 : base + 4'(PB);
      type_d  = eff;
      eieos_d = (eff == BT_OS_EIEOS) | (eieos_q & ~pulse);
    end

    lr_d  = 1'b0;
    err_d = 1'b0;
    adv_d = '0;
    scr_d = '0;
    if (turn_off_i) begin
      lr_d  = 1'b1;
      adv_d = '1;
    end else if (!valid_i) begin
      lr_d = 1'b0;
    end else if (!gen3_i) begin
      lr_d  = lr_g1;
      adv_d = adv_g1;
      scr_d = scr_g1;
    end else begin
      lr_d  = pulse;
      err_d = err_g3;
      adv_d = adv_g3;
      scr_d = scr_g3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      type_q  <= BT_IDLE;
      eieos_q <= 1'b0;
      lr_q    <= 1'b0;
      err_q   <= 1'b0;
      adv_q   <= '0;
      scr_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      eieos_q <= eieos_d;
      lr_q    <= lr_d;
      err_q   <= err_d;
      adv_q   <= adv_d;
      scr_q   <= scr_d;
    end
  end

  assign lfsr_reset_o  = lr_q;
  assign block_err_o   = err_q;
  assign advance_o     = adv_q;
  assign scramble_en_o = scr_q;

endmodule

// File: rtl/scr_ctrl_multilane.sv
// Per-lane scrambler/descrambler control for the PCIe MAC,
// one independent scr_lane_ctrl per lane.
module scr_ctrl_multilane
  import pcie_scr_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int PIPE_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [2:0]                    gen,
  input  logic                          turn_off,
  input  logic                          valid,
  input  logic [LANES-1:0]              block_start,
  input  logic [2*LANES-1:0]            sync_header,
  input  logic [8*PIPE_BYTES*LANES-1:0] data,
  input  logic [PIPE_BYTES*LANES-1:0]   datak,
  output logic [LANES-1:0]              lfsr_reset,
  output logic [PIPE_BYTES*LANES-1:0]   advance,
  output logic [PIPE_BYTES*LANES-1:0]   scramble_en,
  output logic [LANES-1:0]              block_err
);

  localparam int PB = PIPE_BYTES;

  logic gen3;
  assign gen3 = (gen >= 3'd3);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    scr_lane_ctrl #(
      .PB(PB)
    ) u_lane (
      .clk           (clk),
      .rst_n         (rst_n),
      .gen3_i        (gen3),
      .turn_off_i    (turn_off),
      .valid_i       (valid),
      .block_start_i (block_start[l]),
      .sync_header_i (sync_header[2*l +: 2]),
      .data_i        (data[8*PB*l +: 8*PB]),
      .datak_i       (datak[PB*l +: PB]),
      .lfsr_reset_o  (lfsr_reset[l]),
      .advance_o     (advance[PB*l +: PB]),
      .scramble_en_o (scramble_en[PB*l +: PB]),
      .block_err_o   (block_err[l])
    );
  end

endmodule

// File: tb/tb_scr_ctrl_multilane.sv
// Randomized bench for scr_ctrl_multilane: 4-lane x4 and
// 1-lane x1 instances against a block-level reference model.
module tb_scr_ctrl_multilane;

  localparam int LA = 4;
  localparam int PA = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] gen;
  logic       turn_off;
  logic       valid;

  logic [LA-1:0]      bs_a;
  logic [2*LA-1:0]    sh_a;
  logic [8*PA*LA-1:0] d_a;
  logic [PA*LA-1:0]   k_a;
  logic [LA-1:0]      lr_a, err_a;
  logic [PA*LA-1:0]   adv_a, scr_a;

  logic [0:0] bs_b, k_b, lr_b, err_b, adv_b, scr_b;
  logic [1:0] sh_b;
  logic [7:0] d_b;

  scr_ctrl_multilane #(.LANES(LA), .PIPE_BYTES(PA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .gen(gen),
    .turn_off(turn_off), .valid(valid),
    .block_start(bs_a), .sync_header(sh_a),
    .data(d_a), .datak(k_a),
    .lfsr_reset(lr_a), .advance(adv_a),
    .scramble_en(scr_a), .block_err(err_a)
  );

  scr_ctrl_multilane #(.LANES(1), .PIPE_BYTES(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .gen(gen),
    .turn_off(turn_off), .valid(valid),
    .block_start(bs_b), .sync_header(sh_b),
    .data(d_b), .datak(k_b),
    .lfsr_reset(lr_b), .advance(adv_b),
    .scramble_en(scr_b), .block_err(err_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // pos: symbols consumed in the current block, -1 = no block
  // kind: 0 none, 1 data, 2 ts, 3 eieos, 4 skp, 5 other
  typedef struct packed {
    int pos;
    int kind;
    bit pend;
  } lst_t;

  lst_t st_a [LA];
  lst_t st_b;

  task automatic reset_model();
    for (int l = 0; l < LA; l++) st_a[l] = '{-1, 0, 1'b0};
    st_b = '{-1, 0, 1'b0};
  endtask

  task automatic lane_model(
    input int pb, input lst_t si, input bit bs,
    input logic [1:0] sh, input logic [31:0] by,
    input logic [3:0] kf, output lst_t so,
    output bit lr, output bit err,
    output logic [3:0] adv, output logic [3:0] scr);
    int k, s;
    logic [7:0] b;
    so = si; lr = 0; err = 0; adv = '0; scr = '0;
    if (gen < 3) begin
      so = '{-1, 0, 1'b0};
      if (valid)
        for (int j = 0; j < pb; j++) begin
          b = by[8*j +: 8];
          if (!kf[j]) begin
            adv[j] = 1; scr[j] = 1;
          end else if (b == 8'hBC) begin
            adv[j] = 1; lr = 1;
          end else if (b != 8'h1C) begin
            adv[j] = 1;
          end
        end
    end else if (valid) begin
      if (sh == 2'b01) k = 1;
      else if (sh == 2'b10)
        case (by[7:0])
          8'h1E, 8'h2D: k = 2;
          8'h00:        k = 3;
          8'hAA:        k = 4;
          default:      k = 5;
        endcase
      else k = 0;
      if (bs) begin
        err = (k == 0) || (si.pos > 0 && si.pos < 16);
        if (k != 0 && si.pend) begin
          lr = 1; so.pend = 0;
        end
        so.kind = k;
        so.pos  = (k == 0) ? -1 : 0;
      end else if (si.pos == 16) begin
        err = 1; so.kind = 0; so.pos = -1;
      end
      if (so.pos >= 0) begin
        for (int j = 0; j < pb; j++) begin
          s = so.pos + j;
          adv[j] = (so.kind != 4);
          scr[j] = (so.kind == 1) ||
                   (so.kind == 2 && s >= 1 && s <= 13);
        end
        if (so.kind == 3) so.pend = 1;
        so.pos += pb;
      end
    end
    if (turn_off) begin
      lr = 1; err = 0; scr = '0;
      adv = 4'((1 << pb) - 1);
    end
  endtask

  task automatic step();
    logic [LA-1:0]    elr_a, eerr_a;
    logic [PA*LA-1:0] eadv_a, escr_a;
    lst_t ns;
    bit lr, er;
    logic [3:0] ad, sc;
    for (int l = 0; l < LA; l++) begin
      lane_model(PA, st_a[l], bs_a[l], sh_a[2*l +: 2],
                 d_a[32*l +: 32], k_a[4*l +: 4],
                 ns, lr, er, ad, sc);
      st_a[l] = ns;
      elr_a[l] = lr;
      eerr_a[l] = er;
      eadv_a[4*l +: 4] = ad;
      escr_a[4*l +: 4] = sc;
    end
    lane_model(1, st_b, bs_b[0], sh_b, {24'h0, d_b},
               {3'b0, k_b}, ns, lr, er, ad, sc);
    st_b = ns;
    @(posedge clk);
    #1;
    check("lr_a", lr_a, elr_a);
    check("err_a", err_a, eerr_a);
    check("adv_a", adv_a, eadv_a);
    check("scr_a", scr_a, escr_a);
    check("lr_b", lr_b, lr);
    check("err_b", err_b, er);
    check("adv_b", adv_b, ad[0]);
    check("scr_b", scr_b, sc[0]);
    @(negedge clk);
  endtask

  task automatic pick(input int pb, input int pos,
                      output bit bs, output logic [1:0] sh,
                      output logic [7:0] b0);
    if (pos < 0 || pos >= 16) bs = ($urandom % 8) != 0;
    else bs = ($urandom % (64 / pb)) == 0;
    case ($urandom % 10)
      0:       sh = ($urandom % 2) ? 2'b11 : 2'b00;
      1, 2, 3: sh = 2'b01;
      default: sh = 2'b10;
    endcase
    case ($urandom % 6)
      0:       b0 = 8'h1E;
      1:       b0 = 8'h2D;
      2:       b0 = 8'h00;
      3:       b0 = 8'hAA;
      default: b0 = 8'($urandom);
    endcase
  endtask

  task automatic rand_g3();
    bit bs;
    logic [1:0] sh;
    logic [7:0] b0;
    valid    = ($urandom % 6) != 0;
    turn_off = 1'b0;
    gen      = 3'(3 + $urandom % 5);
    for (int i = 0; i < PA * LA; i++) d_a[8*i +: 8] = 8'($urandom);
    k_a = 16'($urandom);
    for (int l = 0; l < LA; l++) begin
      pick(PA, st_a[l].pos, bs, sh, b0);
      bs_a[l] = bs;
      sh_a[2*l +: 2] = sh;
      d_a[32*l +: 8] = b0;
    end
    pick(1, st_b.pos, bs, sh, b0);
    bs_b = bs;
    sh_b = sh;
    d_b  = b0;
    k_b  = 1'($urandom);
  endtask

  task automatic rand_sym(output logic [7:0] b, output logic k);
    case ($urandom % 6)
      0:       begin b = 8'hBC; k = 1; end
      1:       begin b = 8'h1C; k = 1; end
      2:       begin b = 8'($urandom); k = 1; end
      default: begin b = 8'($urandom); k = 0; end
    endcase
  endtask

  task automatic rand_g1();
    logic [7:0] b;
    logic k;
    valid    = ($urandom % 6) != 0;
    turn_off = ($urandom % 8) == 0;
    gen      = 3'($urandom % 3);
    bs_a = 4'($urandom);
    sh_a = 8'($urandom);
    bs_b = 1'($urandom);
    sh_b = 2'($urandom);
    for (int i = 0; i < PA * LA; i++) begin
      rand_sym(b, k);
      d_a[8*i +: 8] = b;
      k_a[i] = k;
    end
    rand_sym(b, k);
    d_b = b;
    k_b = k;
  endtask

  logic [15:0] ts_scr, ts_adv;

  initial begin
    rst_n = 0; gen = 3'd3; turn_off = 0; valid = 0;
    bs_a = '0; sh_a = '0; d_a = '0; k_a = '0;
    bs_b = '0; sh_b = '0; d_b = '0; k_b = '0;
    reset_model();
    #2;
    check("rst_lr", {lr_a, lr_b}, 0);
    check("rst_err", {err_a, err_b}, 0);
    check("rst_adv", {adv_a, adv_b}, 0);
    check("rst_scr", {scr_a, scr_b}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    gen = 3'd1; valid = 1;
    d_a = {4{32'h1C45BC12}};
    k_a = {4{4'b1010}};
    d_b = 8'h12; k_b = 1'b0;
    step();
    check("g1_adv", adv_a[3:0], 4'b0111);
    check("g1_scr", scr_a[3:0], 4'b0101);
    check("g1_lr", lr_a[0], 1'b1);
    turn_off = 1;
    step();
    check("off_adv", adv_a, 16'hFFFF);
    check("off_scr", scr_a, 16'h0000);
    turn_off = 0;

    gen = 3'd3; valid = 1;
    sh_a = {2'b10, 2'b10, 2'b10, 2'b01};
    d_a = '0;
    d_a[32*1 +: 8] = 8'h1E;
    d_a[32*2 +: 8] = 8'h00;
    d_a[32*3 +: 8] = 8'hAA;
    sh_b = 2'b10;
    for (int i = 0; i < 16; i++) begin
      bs_a = (i % 4 == 0) ? 4'hF : 4'h0;
      bs_b = (i == 0);
      d_b  = (i == 0) ? 8'h1E : 8'($urandom);
      step();
      ts_scr[i] = scr_b[0];
      ts_adv[i] = adv_b[0];
    end
    check("ts1_scr", ts_scr, 16'h3FFE);
    check("ts1_adv", ts_adv, 16'hFFFF);

    for (int i = 0; i < 600; i++) begin
      rand_g3();
      step();
    end

    rand_g3();
    valid = 1;
    #2;
    rst_n = 0;
    #1;
    check("arst_out", {lr_a, err_a, adv_a, scr_a}, 0);
    check("arst_out_b", {lr_b, err_b, adv_b, scr_b}, 0);
    @(negedge clk);
    rst_n = 1;
    reset_model();

    for (int i = 0; i < 300; i++) begin
      rand_g3();
      step();
    end
    for (int i = 0; i < 300; i++) begin
      rand_g1();
      step();
    end
    for (int i = 0; i < 300; i++) begin
      rand_g3();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
